// File: rtl/mem_nzlat_initiator.sv
// Single-outstanding initiator for a non-zero-latency memory responder:
// issues one-cycle read/write pulses, waits for ready (with watchdog), returns a response.
module mem_nzlat_initiator #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 1024,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ADDR_WIDTH    = $clog2(DEPTH),
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            state;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [STRB_WIDTH-1:0] lat_wstrb;
    logic [CNT_WIDTH-1:0]  wd_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  issuing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            wd_cnt    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_we ? req_wdata : '0;
                        lat_wstrb <= req_we ? req_wstrb : '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // ready wins over a watchdog expiry landing in the same cycle
                    if (mem_ready) begin
                        rdata_q <= lat_we ? '0 : mem_rdata;
                        err_q   <= 1'b0;
                        state   <= S_RESP;
                    end else if (wd_cnt == CNT_LIMIT) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_WIDTH'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign issuing    = (state == S_ISSUE);
    // held low while reset is asserted so every output reads 0 during reset
    assign req_ready  = rst_n && (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = issuing ? lat_addr  : '0;
    assign mem_wdata  = issuing ? lat_wdata : '0;
    assign mem_wstrb  = issuing ? lat_wstrb : '0;
    assign mem_write  = issuing && lat_we;
    assign mem_read   = issuing && !lat_we;

endmodule

// File: tb/tb_mem_nzlat_initiator.sv
// Scoreboard bench for mem_nzlat_initiator: a behavioural responder with programmable
// latency, expected responses queued at issue time and checked by an independent monitor.
module tb_mem_nzlat_initiator;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int TO    = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = DW / 8;
    localparam logic [DW-1:0] IDLE_D = 32'hBAD0BAD0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_write;
    logic          mem_read;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    mem_nzlat_initiator #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rsp_lat = 0;
    bit            rsp_stub = 1'b0;
    int            stray_req = 0;
    logic [DW-1:0] rmem   [DEPTH];
    logic [DW-1:0] refmem [DEPTH];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < SW; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Responder: one pulse at a time, ready rsp_lat+1 cycles after the pulse cycle.
    initial begin
        int stray_done;
        logic [DW-1:0] d;
        stray_done = 0;
        mem_ready  = 1'b0;
        mem_rdata  = IDLE_D;
        for (int i = 0; i < DEPTH; i++) rmem[i] = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                stray_done = stray_req;
                mem_ready  = 1'b1;
                mem_rdata  = 32'hCAFEF00D;
                @(negedge clk);
                mem_ready  = 1'b0;
                mem_rdata  = IDLE_D;
            end else if (!rsp_stub && (mem_read || mem_write)) begin
                if (mem_write) rmem[mem_addr] = merge(rmem[mem_addr], mem_wdata, mem_wstrb);
                d = mem_write ? '0 : rmem[mem_addr];
                repeat (rsp_lat + 1) @(posedge clk);
                #1;
                mem_ready = 1'b1;
                mem_rdata = d;
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                mem_rdata = IDLE_D;
            end
        end
    end

    // Monitor: every new response is popped from the scoreboard and compared.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            chk("ready_valid_exclusive", 64'(req_ready && resp_valid), 64'(0));
            if (resp_valid && !prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_response", 64'(resp_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            prev = resp_valid;
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] ws, input logic [DW-1:0] exp_rd, input logic exp_err,
                         input int exp_lat, input bit push);
        int n;
        exp_t e;
        logic [63:0] pv;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", 64'(req_ready), 64'(1));
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        if (push) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.cyc   = cyc + 3 + exp_lat;
            q.push_back(e);
        end
        pv = 64'({we, ~we, addr, (we ? wd : DW'(0)), (we ? ws : SW'(0))});
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        chk("issue_pulse", 64'({mem_write, mem_read, mem_addr, mem_wdata, mem_wstrb}), pv);
        @(negedge clk);
        chk("pulse_one_cycle", 64'({mem_write, mem_read, mem_addr, mem_wdata, mem_wstrb}), 64'(0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'(0));
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 64'({req_ready, resp_valid, resp_err, mem_write, mem_read, mem_addr, mem_wstrb}), 64'(0));
        chk(name, 64'({resp_rdata, mem_wdata}), 64'(0));
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        int            n;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) refmem[i] = '0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", 64'({req_ready, resp_valid}), 64'(2'b10));

        // write then read, zero-latency responder; read carries junk wdata that must be dropped
        rsp_lat = 0;
        issue(1'b1, 6'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0, 1'b1);
        issue(1'b0, 6'h10, 32'h12345678, 4'hF, 32'hDEADBEEF, 1'b0, 0, 1'b1);

        // partial strobe
        rsp_lat = 2;
        issue(1'b1, 6'd3, 32'h11223344, 4'hF, 32'h0, 1'b0, 2, 1'b1);
        issue(1'b1, 6'd3, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 2, 1'b1);
        issue(1'b0, 6'd3, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 2, 1'b1);
        issue(1'b1, 6'd4, 32'h55555555, 4'h0, 32'h0, 1'b0, 2, 1'b1);
        issue(1'b0, 6'd4, 32'h0, 4'h0, 32'h0, 1'b0, 2, 1'b1);
        wait_idle();

        // backpressure
        rsp_lat    = 0;
        resp_ready = 1'b0;
        issue(1'b0, 6'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, 1'b1);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 6'd9;
            req_wdata = 32'h01020304;
            req_wstrb = 4'hF;
            chk("backpressure_hold", 64'({resp_valid, resp_err, req_ready, mem_write, mem_read, resp_rdata}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF}));
            @(negedge clk);
        end
        req_valid  = 1'b0;
        req_we     = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("backpressure_release", 64'({resp_valid, req_ready}), 64'(2'b01));
        wait_idle();

        // timeout, then a stray ready while idle
        rsp_stub = 1'b1;
        issue(1'b0, 6'd7, 32'h0, 4'h0, 32'h0, 1'b1, TO, 1'b1);
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_seen", 64'(q.size()), 64'(0));
        @(negedge clk);
        stray_req++;
        repeat (6) @(negedge clk);
        chk("stray_ready_ignored", 64'({req_ready, resp_valid, mem_read, mem_write}), 64'(4'b1000));

        // reset while waiting: no response may follow
        issue(1'b0, 6'd5, 32'h0, 4'h0, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid_wait");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release", 64'({req_ready, resp_valid}), 64'(2'b10));
        repeat (15) @(negedge clk);
        chk("no_resp_after_reset", 64'({resp_valid, q.size() == 0}), 64'(2'b01));
        rsp_stub = 1'b0;

        // random traffic at latency 5, expectations from the reference array
        rsp_lat = 5;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = AW'(32 + $urandom_range(0, 7));
            wd = $urandom;
            ws = SW'($urandom_range(0, 15));
            if (we) begin
                refmem[a] = merge(refmem[a], wd, ws);
                issue(1'b1, a, wd, ws, 32'h0, 1'b0, 5, 1'b1);
            end else begin
                issue(1'b0, a, wd, ws, refmem[a], 1'b0, 5, 1'b1);
            end
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_nzlat_initiator.md
# mem_nzlat_initiator

Initiator for the non-zero-latency memory port. Accepts single load/store requests from a core-side valid/ready channel, drives one-cycle `read`/`write` pulses with address, data and strobes to a memory responder, and waits for its `ready` pulse. Captures read data on that pulse and returns a response on a valid/ready channel. A watchdog turns a missing `ready` into an error response. Sits between a core's LSU/fetch stage and a memory responder instance.

## Interface
- `DATA_WIDTH`, 32, data width in bits; must be a multiple of 8.
- `DEPTH`, 1024, memory depth in words; `ADDR_WIDTH = $clog2(DEPTH)` (localparam).
- `TIMEOUT_CYCLES`, 64, maximum cycles spent in WAIT before an error response; must be ≥ 1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wstrb`  in  DATA_WIDTH/8  byte enables for writes.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  core accepts response.
- `resp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `resp_err`  out  1  1 = timeout.
- `mem_addr`  out  ADDR_WIDTH  to responder `addr`.
- `mem_wdata`  out  DATA_WIDTH  to responder `wdata`.
- `mem_wstrb`  out  DATA_WIDTH/8  to responder `wstrb`.
- `mem_write`  out  1  one-cycle write pulse.
- `mem_read`  out  1  one-cycle read pulse.
- `mem_rdata`  in  DATA_WIDTH  responder read data; valid only while `mem_ready` = 1.
- `mem_ready`  in  1  responder completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch `req_we`, `req_addr`, `req_wdata` and `req_wstrb`, then go to ISSUE.
  - For reads, the latched `wdata`/`wstrb` are zeroed.
- ISSUE (exactly one cycle):
  - `mem_addr`/`mem_wdata`/`mem_wstrb` are driven from latched values.
  - `mem_write` = we; `mem_read` = !we. Both are never high together.
  - Next state is WAIT; the watchdog counter is cleared to 0.
- WAIT:
  - All `mem_*` outputs return to 0.
  - On `mem_ready` = 1: capture `mem_rdata` for reads (0 for writes), set `resp_err` = 0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES with no `mem_ready`, set `resp_err` = 1 and `resp_rdata` = 0, then go to RESP.
- RESP:
  - `resp_valid` = 1, with `resp_rdata`/`resp_err` held stable until `resp_ready`.
  - On `resp_ready`, go to IDLE.
  - No new request is accepted in RESP.
- Watchdog counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.
- A `mem_ready` seen in IDLE, ISSUE or RESP is ignored: it produces no response and no state change.
- One transaction is outstanding at most. Write strobe 0 is still issued and still waits for `ready`.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are 0 outside ISSUE.

## Timing
- Reset values: `req_ready` = 1 once reset is released. `resp_valid`, `resp_err`, `resp_rdata`, `mem_*` outputs and all latches and counters = 0.
- Reset asserted mid-transaction (any state) aborts the transaction immediately. No response is produced.
- Request accepted at edge ending cycle T; the pulse is high in cycle T+1 only.
- A responder with drawn latency k asserts `mem_ready` in cycle T+2+k. `resp_valid` rises in cycle T+3+k.
- Zero-latency responder: `ready` arrives in T+2 and `resp_valid` rises in T+3.
- Timeout: `resp_valid` with `resp_err` = 1 rises TIMEOUT_CYCLES+2 cycles after the ISSUE cycle.
- Back-to-back: with `resp_ready` held 1, the response completes in its first RESP cycle. IDLE follows, and the next request can be accepted there. Minimum spacing between pulses is therefore 4 cycles plus latency. The next pulse always lands while the responder is in Idle, never in its busy states.
- `req_ready` and `resp_valid` are mutually exclusive.

## Test plan
- Write then read: write addr 0x10, data 0xDEADBEEF, strb 0xF, then read 0x10. Expected: two single-cycle pulses; read response 0xDEADBEEF, `resp_err` = 0.
- Partial strobe: write 0x11223344 to addr 3, then 0xAABBCCDD with strb 0x5, then read addr 3. Expected: 0x11BB33DD.
- Backpressure: hold `resp_ready` = 0 for 10 cycles after a read. Expected: `resp_valid`/`resp_rdata` stable, `req_ready` = 0, and no new pulse despite `req_valid` = 1.
- Timeout: stub that never asserts `ready`, TIMEOUT_CYCLES = 8. Expected: `resp_err` = 1, `resp_rdata` = 0, `resp_valid` exactly 10 cycles after the ISSUE cycle; stray `ready` injected later is ignored.
- Random latency: 200 random read/write requests against the memory responder with READ/WRITE latency 5. Expected: data matches the reference model, every pulse is one cycle, and each response arrives k+3 cycles after acceptance.
- Reset mid-WAIT: assert `rst_n` = 0 during WAIT. Expected: all outputs 0 immediately, `req_ready` = 1 after release, no response emitted.
